// File: rtl/fdiv_pipe.sv
// ---------------------------------------------------------------------------
// fdiv_pipe
//
// Pipelined single-precision divider. The quotient a / b is formed as
// a * (1/b): the divisor is handed to an external combinational reciprocal
// unit (finv), whose result is registered next to the dividend. The mantissas
// are then multiplied, and the product is normalised and packed. One
// operation per cycle; an operation accepted at edge k is presented on the
// output from edge k+2 onward.
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst        in   1   synchronous active-high reset
//   in_valid   in   1   operand pair valid
//   in_ready   out  1   operand pair accepted this cycle
//   in_a       in   32  dividend (IEEE single)
//   in_b       in   32  divisor (IEEE single)
//   inv_x      out  32  to finv.x, combinationally equal to in_b
//   inv_y      in   32  from finv.y (reciprocal of in_b)
//   inv_ovf    in   1   from finv.ovf
//   out_valid  out  1   quotient valid
//   out_ready  in   1   consumer takes the quotient
//   out_y      out  32  quotient
//   out_ovf    out  1   overflow / underflow / divide-by-zero
//
// Build option:
//   FDIV_ROUND_EN  defined   -> round-to-nearest-even on the mantissa
//                  undefined -> truncation (round toward zero)
// No NaN, infinity or denormal support: an exponent field of 0 means zero.
// ---------------------------------------------------------------------------
module fdiv_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic [31:0] inv_x,
    input  logic [31:0] inv_y,
    input  logic        inv_ovf,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_y,
    output logic        out_ovf
);

    // Truncation never looks below the kept mantissa, so the product's low
    // 23 bits are only stored when rounding needs them for guard/sticky.
`ifdef FDIV_ROUND_EN
    localparam int LSB = 0;
`else
    localparam int LSB = 23;
`endif
    localparam int PW = 48 - LSB;

    logic w_adv;

    // Stage 1 registers
    logic        r_v1;
    logic [31:0] r_a1;
    logic [31:0] r_r1;
    logic        r_invOvf1;
    logic        r_zeroDiv1;

    // Stage 2 registers
    logic              r_v2;
    logic              r_s2;
    logic [PW-1:0]     r_p2;
    logic signed [9:0] r_e2;
    logic              r_aZero2;
    logic              r_invOvf2;
    logic              r_zeroDiv2;

    // Stage 2 combinational helpers
    logic [23:0]       w_mA;
    logic [23:0]       w_mR;
    logic [PW-1:0]     w_p;
    logic signed [9:0] w_e;

    // Output-stage combinational helpers
    logic              w_top;
    logic [22:0]       w_mant;
    logic signed [9:0] w_eNorm;
    logic [23:0]       w_mantRnd;
    logic              w_inc;
    logic [22:0]       w_mantFin;
    logic signed [9:0] w_eFin;
    logic [31:0]       w_y;
    logic              w_ovf;

    // One global enable moves every stage together; the pipe only freezes
    // when a finished result is waiting on an unready consumer.
    assign w_adv    = ~out_valid | out_ready;
    assign in_ready = w_adv;
    assign inv_x    = in_b;

    // Stage 1: capture the dividend together with finv's answer for the
    // divisor, which is valid in the same cycle because finv is combinational.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1 <= 1'b0;
        end else if (w_adv) begin
            r_v1       <= in_valid;
            r_a1       <= in_a;
            r_r1       <= inv_y;
            r_invOvf1  <= inv_ovf;
            r_zeroDiv1 <= (in_b[30:23] == 8'd0);
        end
    end

    // Stage 2 arithmetic: full 24x24 mantissa product (hidden bits restored)
    // and the biased exponent sum kept signed so under/overflow stays visible.
    assign w_mA = {1'b1, r_a1[22:0]};
    assign w_mR = {1'b1, r_r1[22:0]};
    assign w_p  = PW'(({24'd0, w_mA} * {24'd0, w_mR}) >> LSB);
    assign w_e  = $signed({2'b00, r_a1[30:23]}) + $signed({2'b00, r_r1[30:23]})
                  - 10'sd127;

    // Stage 2 registers: product, exponent, sign and the exception flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v2 <= 1'b0;
        end else if (w_adv) begin
            r_v2       <= r_v1;
            r_s2       <= r_a1[31] ^ r_r1[31];
            r_p2       <= w_p;
            r_e2       <= w_e;
            r_aZero2   <= (r_a1[30:23] == 8'd0);
            r_invOvf2  <= r_invOvf1;
            r_zeroDiv2 <= r_zeroDiv1;
        end
    end

    // Normalisation: the product of two [1,2) mantissas lies in [1,4), so at
    // most one right shift is needed, which bumps the exponent by one.
    always_comb begin
        w_top   = r_p2[47-LSB];
        w_eNorm = r_e2 + $signed({9'd0, w_top});
        if (w_top) begin
            w_mant = r_p2[46-LSB -: 23];
        end else begin
            w_mant = r_p2[45-LSB -: 23];
        end
    end

    // Rounding: a mantissa carry-out wraps the fraction to zero and bumps the
    // exponent, so it must happen before the overflow test below.
    always_comb begin
        w_inc = 1'b0;
`ifdef FDIV_ROUND_EN
        if (w_top) begin
            w_inc = r_p2[23] & ((|r_p2[22:0]) | w_mant[0]);
        end else begin
            w_inc = r_p2[22] & ((|r_p2[21:0]) | w_mant[0]);
        end
`endif
        w_mantRnd = {1'b0, w_mant} + {23'd0, w_inc};
        if (w_mantRnd[23]) begin
            w_mantFin = 23'd0;
            w_eFin    = w_eNorm + 10'sd1;
        end else begin
            w_mantFin = w_mantRnd[22:0];
            w_eFin    = w_eNorm;
        end
    end

    // Exception priority: a zero divisor or a failed reciprocal outranks a
    // zero dividend, which outranks exponent range checks. Every zero result
    // is +0 regardless of the computed sign.
    always_comb begin
        w_y   = 32'd0;
        w_ovf = 1'b0;
        if (r_zeroDiv2) begin
            w_ovf = 1'b1;
        end else if (r_invOvf2) begin
            w_ovf = 1'b1;
        end else if (r_aZero2) begin
            w_ovf = 1'b0;
        end else if (w_eFin <= 10'sd0) begin
            w_ovf = 1'b1;
        end else if (w_eFin >= 10'sd255) begin
            w_y   = {r_s2, 8'hFF, 23'd0};
            w_ovf = 1'b1;
        end else begin
            w_y   = {r_s2, w_eFin[7:0], w_mantFin};
        end
    end

    // Output register: holds the result steady for as long as the consumer
    // stalls; bubbles flow through as out_valid=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_y     <= 32'd0;
            out_ovf   <= 1'b0;
        end else if (w_adv) begin
            out_valid <= r_v2;
            out_y     <= w_y;
            out_ovf   <= w_ovf;
        end
    end

endmodule
